// File: rtl/spi_pkg.sv
// Shared constants for the SPI register responder: FSM encoding and address-byte field positions.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } spi_state_e;

  localparam int RW_BIT     = 7;
  localparam int ADDR_LSB   = 1;
  localparam int ADDR_W_DEF = 6;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous line, with single-cycle rise/fall pulses
// derived from the synchronized level and its previous value.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 responder serving an internal byte register bank with MFRC522-style address/data frames.
// Build option SPI_SLV_TRISTATE_EN: MISO floats (1'bz) whenever synchronized NSS is high.
module spi_slave_regs
  import spi_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SCK,
  input  logic              NSS,
  input  logic              MOSI,
  output logic              MISO,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done
);

  localparam int DEPTH = 1 << ADDR_W;

  logic sck_lvl_unused, sck_rise, sck_fall;
  logic nss_s, nss_rise, nss_fall;
  logic mosi_s;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk    (clk),
    .reset  (reset),
    .din_i  (SCK),
    .sync_o (sck_lvl_unused),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  // Reset as "selected" so an NSS already low at reset release never looks like a fresh fall.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_nss_sync (
    .clk    (clk),
    .reset  (reset),
    .din_i  (NSS),
    .sync_o (nss_s),
    .rise_o (nss_rise),
    .fall_o (nss_fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mosi_sync_q <= '0;
    else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  spi_state_e        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        rx_q, rx_d;
  logic              byte_done_q, byte_done_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        tx_next_q, tx_next_d;
  logic [7:0]        tx_sh_q, tx_sh_d;
  logic              rd_end_q, rd_end_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] rx_addr;
  logic              spi_we;
  logic [7:0]        bank_q [DEPTH];

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_d         = rx_q;
    byte_done_d  = byte_done_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    tx_next_d    = tx_next_q;
    tx_sh_d      = tx_sh_q;
    rd_end_d     = rd_end_q;
    wr_strobe_d  = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    spi_we       = 1'b0;
    rx_byte      = {rx_q[6:0], mosi_s};
    rx_addr      = rx_byte[ADDR_LSB +: ADDR_W];

    if (nss_rise) begin
      state_d      = ST_IDLE;
      frame_done_d = (state_q == ST_DATA);
      byte_done_d  = 1'b0;
      tx_sh_d      = 8'h00;
    end else if (nss_fall) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      rw_d        = 1'b0;
      tx_next_d   = 8'h00;
      tx_sh_d     = 8'h00;
      rd_end_d    = 1'b0;
    end else if (state_q != ST_IDLE && !nss_s) begin
      if (sck_rise) begin
        rx_d      = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_done_d = 1'b1;
          tx_next_d   = 8'h00;
          case (state_q)
            ST_ADDR: begin
              state_d = ST_DATA;
              rw_d    = rx_byte[RW_BIT];
              addr_d  = rx_addr;
              if (rx_byte[RW_BIT]) tx_next_d = bank_q[rx_addr];
            end
            ST_DATA: begin
              if (!rw_q) begin
                spi_we      = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = addr_q;
                wr_data_d   = rx_byte;
              end else if (!rd_end_q && rx_byte != 8'h00) begin
                tx_next_d = bank_q[rx_addr];
              end else begin
                rd_end_d = 1'b1;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end else if (sck_fall) begin
        if (byte_done_q) begin
          tx_sh_d     = tx_next_q;
          byte_done_d = 1'b0;
        end else begin
          tx_sh_d = {tx_sh_q[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      rx_q         <= 8'h00;
      byte_done_q  <= 1'b0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      tx_next_q    <= 8'h00;
      tx_sh_q      <= 8'h00;
      rd_end_q     <= 1'b0;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      byte_done_q  <= byte_done_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      tx_next_q    <= tx_next_d;
      tx_sh_q      <= tx_sh_d;
      rd_end_q     <= rd_end_d;
      wr_strobe_q  <= wr_strobe_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  // SPI write is applied last so it wins a same-address collision with the host port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= 8'h00;
    end else begin
      if (host_we) bank_q[host_addr] <= host_wdata;
      if (spi_we)  bank_q[addr_q]    <= rx_byte;
    end
  end

  assign host_rdata = bank_q[host_addr];
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;

`ifdef SPI_SLV_TRISTATE_EN
  assign MISO = nss_s ? 1'bz : tx_sh_q[7];
`else
  assign MISO = nss_s ? 1'b0 : tx_sh_q[7];
`endif

endmodule

// File: tb/tb_spi_slave_regs.sv
// Bench for spi_slave_regs: directed frames plus randomized frames checked against a byte-level frame model.
module tb_spi_slave_regs;

  localparam int HALF = 8;

  logic       clk, reset, SCK, NSS, MOSI, MISO;
  logic       host_we;
  logic [5:0] host_addr;
  logic [7:0] host_wdata, host_rdata;
  logic       wr_strobe, frame_done;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;

  spi_slave_regs dut (
    .clk(clk), .reset(reset), .SCK(SCK), .NSS(NSS), .MOSI(MOSI), .MISO(MISO),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fd_seen = 0;
  int exp_fd = 0;
  int wr_seen = 0;
  int nss_hi_cnt = 0;
  logic [5:0]  last_wa;
  logic [7:0]  last_wd;
  logic [7:0]  model_bank [64];
  logic [13:0] exp_wr [$];
  logic [7:0]  fb [8];
  logic [7:0]  em [8];
  logic [7:0]  got [8];
  logic [5:0]  coll_addr;
  logic [7:0]  coll_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare: write events against the model queue, idle MISO level, pulse counting.
  always @(negedge clk) begin
    if (!reset) begin
      nss_hi_cnt = 0;
    end else begin
      if (wr_strobe) begin
        wr_seen++;
        last_wa = wr_addr;
        last_wd = wr_data;
        if (exp_wr.size() == 0) begin
          chk("wr_unexpected", {18'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
        end else begin
          chk("wr_pair", {18'd0, wr_addr, wr_data}, {18'd0, exp_wr.pop_front()});
        end
      end
      if (frame_done) fd_seen++;
      if (NSS) nss_hi_cnt++;
      else     nss_hi_cnt = 0;
      if (nss_hi_cnt >= 4) begin
`ifdef SPI_SLV_TRISTATE_EN
        chk("miso_idle", {31'd0, MISO}, {31'd0, 1'bz});
`else
        chk("miso_idle", {31'd0, MISO}, 32'd0);
`endif
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [5:0] a, input logic [7:0] d);
    host_addr = a; host_wdata = d; host_we = 1'b1;
    clks(1);
    host_we = 1'b0;
    model_bank[a] = d;
  endtask

  task automatic chk_bank(input logic [5:0] a, input logic [7:0] exp);
    host_addr = a;
    #1;
    chk("host_rdata", {24'd0, host_rdata}, {24'd0, exp});
  endtask

  // Shift nbits of b MSB first; MISO is sampled just before each SCK rise, as an initiator would.
  task automatic xfer(input logic [7:0] b, input int nbits, input bit coll, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      MOSI = b[i];
      clks(HALF);
      r[i] = MISO;
      SCK = 1'b1;
      if (coll && i == 0) begin
        clks(2);
        host_addr = coll_addr; host_wdata = coll_data; host_we = 1'b1;
        clks(1);
        host_we = 1'b0;
        clks(HALF - 3);
      end else begin
        clks(HALF);
      end
      SCK = 1'b0;
    end
  endtask

  // nb full bytes from fb[], then ab bits of fb[nb] before NSS rises.
  task automatic run_frame(input int nb, input int ab, input bit coll);
    logic       rw;
    logic [5:0] a;
    logic [7:0] nxt;
    bit         ended;
    if (coll) model_bank[coll_addr] = coll_data;
    rw = fb[0][7];
    a = fb[0][6:1];
    em[0] = 8'h00;
    nxt = rw ? model_bank[a] : 8'h00;
    ended = 0;
    for (int i = 1; i < nb; i++) begin
      em[i] = nxt;
      if (!rw) begin
        model_bank[a] = fb[i];
        exp_wr.push_back({a, fb[i]});
      end else if (ended || fb[i] == 8'h00) begin
        nxt = 8'h00;
        ended = 1;
      end else begin
        nxt = model_bank[fb[i][6:1]];
      end
    end
    if (nb >= 1) exp_fd++;

    NSS = 1'b0;
    clks(HALF);
    for (int i = 0; i < nb; i++) xfer(fb[i], 8, coll && (i == nb - 1), got[i]);
    if (ab > 0) xfer(fb[nb], ab, 1'b0, got[nb]);
    clks(HALF);
    NSS = 1'b1;
    clks(12);
    for (int i = 0; i < nb; i++) chk("miso_byte", {24'd0, got[i]}, {24'd0, em[i]});
    chk("wr_drain", exp_wr.size(), 0);
    chk("frame_done_cnt", fd_seen, exp_fd);
  endtask

  initial begin
    int w0, nb, ab;
    logic [7:0] tmp;
    reset = 1'b0; SCK = 1'b0; NSS = 1'b1; MOSI = 1'b0;
    host_we = 1'b0; host_addr = 6'd0; host_wdata = 8'h00;
    coll_addr = 6'd0; coll_data = 8'h00;
    for (int i = 0; i < 64; i++) model_bank[i] = 8'h00;
    clks(4);
    chk("rst_miso", {31'd0, MISO}, 32'd0);
    chk("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    chk("rst_wr_addr", {26'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk_bank(6'h05, 8'h00);
    reset = 1'b1;
    clks(8);

    // Single write to 0x05
    w0 = wr_seen;
    fb[0] = 8'h0A; fb[1] = 8'h5C;
    run_frame(2, 0, 1'b0);
    chk("t1_strobes", wr_seen - w0, 1);
    chk("t1_wr_addr", {26'd0, last_wa}, 32'h05);
    chk("t1_wr_data", {24'd0, last_wd}, 32'h5C);
    chk_bank(6'h05, 8'h5C);

    // Read chain 0x12, 0x13, terminated by 0x00
    host_write(6'h12, 8'hA7);
    host_write(6'h13, 8'h3C);
    w0 = wr_seen;
    fb[0] = 8'hA4; fb[1] = 8'hA6; fb[2] = 8'h00;
    run_frame(3, 0, 1'b0);
    chk("t2_byte1", {24'd0, got[1]}, 32'hA7);
    chk("t2_byte2", {24'd0, got[2]}, 32'h3C);
    chk("t2_strobes", wr_seen - w0, 0);

    // Burst write to 0x08 overwrites in place
    w0 = wr_seen;
    fb[0] = 8'h10; fb[1] = 8'h11; fb[2] = 8'h22; fb[3] = 8'h33;
    run_frame(4, 0, 1'b0);
    chk("t3_strobes", wr_seen - w0, 3);
    chk_bank(6'h08, 8'h33);

    // Data byte aborted after 5 bits
    w0 = wr_seen;
    fb[0] = 8'h0A; fb[1] = 8'hFF;
    run_frame(1, 5, 1'b0);
    chk("t4_strobes", wr_seen - w0, 0);
    chk_bank(6'h05, 8'h5C);

    // Reset mid-read, then NSS still low must not start a frame
    NSS = 1'b0;
    clks(HALF);
    xfer(8'hA4, 8, 1'b0, tmp);
    xfer(8'hA6, 4, 1'b0, tmp);
    reset = 1'b0;
    clks(2);
    chk("mid_rst_miso", {31'd0, MISO}, 32'd0);
    chk("mid_rst_wr_addr", {26'd0, wr_addr}, 32'd0);
    chk("mid_rst_wr_data", {24'd0, wr_data}, 32'd0);
    for (int i = 0; i < 64; i++) model_bank[i] = 8'h00;
    reset = 1'b1;
    clks(4);
    xfer(8'h0A, 8, 1'b0, tmp);
    xfer(8'h33, 8, 1'b0, tmp);
    chk("stale_nss_miso", {24'd0, tmp}, 32'd0);
    clks(HALF);
    NSS = 1'b1;
    clks(12);
    chk("stale_nss_fd", fd_seen, exp_fd);
    chk_bank(6'h12, 8'h00);
    chk_bank(6'h05, 8'h00);
    w0 = wr_seen;
    fb[0] = 8'h0A; fb[1] = 8'h01;
    run_frame(2, 0, 1'b0);
    chk("t5_strobes", wr_seen - w0, 1);
    chk("t5_wr_data", {24'd0, last_wd}, 32'h01);

    // Same-clk collisions: same address (SPI wins), different address (both land)
    coll_addr = 6'h05; coll_data = 8'h11;
    fb[0] = 8'h0A; fb[1] = 8'h77;
    run_frame(2, 0, 1'b1);
    chk_bank(6'h05, 8'h77);
    coll_addr = 6'h07; coll_data = 8'h66;
    fb[0] = 8'h0C; fb[1] = 8'h55;
    run_frame(2, 0, 1'b1);
    chk_bank(6'h06, 8'h55);
    chk_bank(6'h07, 8'h66);

    // Randomized frames against the model
    for (int f = 0; f < 24; f++) begin
      repeat ($urandom_range(0, 3)) host_write(6'($urandom), 8'($urandom));
      nb = $urandom_range(1, 4);
      fb[0] = 8'($urandom);
      for (int i = 1; i <= nb; i++)
        fb[i] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run_frame(nb, ab, 1'b0);
      chk_bank(fb[0][6:1], model_bank[fb[0][6:1]]);
    end
    for (int i = 0; i < 64; i++) chk_bank(6'(i), model_bank[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
